spi_resp_slv: RTL
=================

Name: spi_resp_slv

Overview:
- SPI responder: the far end of the DSO's single-SS SPI master. Models the calibration EEPROM and digital-pot side of the link.
- Receives 16-bit MSB-first mode-0 frames on MOSI and returns a preloaded 16-bit response on MISO.
- Oversamples SCLK/SS_n/MOSI with the system clock. Used in the DSO bench and as the EEPROM/pot front end in FPGA test builds.

Parameters:
- DW, 16, frame width in bits; also sets the widths of cmd_rcvd and tx_data.
- SYNC_STAGES, 2, number of synchronizer flops on SCLK, SS_n and MOSI (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge
- SS_n  input  1  slave select from master (active low, asynchronous to clk)
- SCLK  input  1  SPI clock from master (asynchronous); high and low phases each ≥3 clk
- MOSI  input  1  serial data from master
- MISO  output  1  serial response to master
- wrt  input  1  one-cycle strobe; loads tx_data into the response buffer
- tx_data  input  DW  response word
- rsp_rdy  output  1  response buffer holds fresh data not yet consumed by a frame
- cmd_rcvd  output  DW  last complete received frame
- cmd_rdy  output  1  sticky; a new cmd_rcvd is valid
- clr_cmd_rdy  input  1  clears cmd_rdy
- frame_err  output  1  one-cycle pulse on an aborted or over-length frame

Behaviour:
- Reset: synchronous active-low; only the clk edge with rst_n low resets.
  - Outputs at reset: cmd_rcvd=0, cmd_rdy=0, rsp_rdy=0, frame_err=0, MISO=0.
  - Internal state at reset: buffer=0, shift reg=0, bit counter=0, state=WAIT_HIGH, synchronizer flops=1.
- Inputs pass through SYNC_STAGES flops plus one edge-detect flop. Edge events are fall_ss, rise_ss, rise_sclk and fall_sclk.
- Event latency: an event registers SYNC_STAGES+1 clk after the pin edge.
- State machine:
  - WAIT_HIGH: ignore all activity until synchronized SS_n=1, then go to IDLE. This guarantees that a reset mid-frame discards the rest of that frame.
  - IDLE, on fall_ss: load shift reg from buffer, clear bit counter, clear rsp_rdy, go to ACTIVE.
  - ACTIVE, on rise_sclk: capture synchronized MOSI into a sample bit and increment the bit counter (saturating at DW+1).
  - ACTIVE, on fall_sclk: shift reg <= {shift[DW-2:0], sample}.
  - ACTIVE, on rise_ss with count==DW: cmd_rcvd <= shift reg, including the last sample if its shift has not yet occurred. Set cmd_rdy. Go to IDLE.
  - ACTIVE, on rise_ss with count≠DW: frame_err=1 for one cycle. cmd_rcvd and cmd_rdy are unchanged. Go to IDLE.
- MISO = shift reg MSB, registered. It is valid SYNC_STAGES+2 clk after the SS_n fall and updates after each fall_sclk.
- Response handshake:
  - wrt: buffer <= tx_data and rsp_rdy <= 1.
  - wrt in the same cycle as fall_ss: tx_data bypasses into the shift reg and rsp_rdy ends at 0.
  - wrt during ACTIVE: updates the buffer only; the frame in flight is unaffected.
  - Frame with no preceding wrt: the previous buffer contents are re-sent and rsp_rdy stays 0.
- cmd_rdy:
  - Set by frame completion, cleared by clr_cmd_rdy.
  - Completion and clear in the same cycle: completion wins, cmd_rdy=1.
  - Also cleared on fall_ss of a new frame.
- Bit order is MSB first. No arithmetic beyond the counter, which is clog2(DW+2) bits wide.

Optional Feature:
- Macro SPI_RESP_TRI_EN.
- When defined: MISO=1'bz whenever synchronized SS_n=1 or state≠ACTIVE, so several responders can share the MISO line.
- When not defined: MISO is driven 0 outside ACTIVE.

Test Plan:
- Normal frame: wrt with tx_data=16'hA55A (rsp_rdy→1), then master sends 16'h13DD. Required: master captures 16'hA55A on MISO, rsp_rdy→0 at frame start, cmd_rcvd=16'h13DD, cmd_rdy=1.
- Aborted frame: SS_n raised after 9 SCLKs. Required: frame_err high exactly 1 clk, cmd_rcvd stays 16'h13DD, cmd_rdy unchanged. A 17-SCLK frame also gives frame_err.
- cmd_rdy precedence: clr_cmd_rdy pulse gives cmd_rdy=0 next clk. clr_cmd_rdy on the completion cycle of frame 16'h5CEF gives cmd_rdy=1 and cmd_rcvd=16'h5CEF.
- No fresh response: two back-to-back frames with no wrt between them. Required: second frame returns the same buffer word and rsp_rdy stays 0. wrt coinciding with fall_ss of tx_data=16'h00EF sends 16'h00EF.
- Reset mid-frame: rst_n low at bit 7, released while SS_n is still low. Required: no cmd_rdy and no frame_err for that frame. The next full frame 16'h2CBF is received correctly.
- Idle MISO: SS_n high gives MISO=z with SPI_RESP_TRI_EN defined, and 0 without it.

Source files
------------

// File: rtl/spi_resp_slv.sv
// SPI mode-0 responder: oversamples SCLK/SS_n/MOSI, returns a preloaded DW-bit word, captures the command.
// Optional SPI_RESP_TRI_EN macro tri-states MISO whenever the responder is not selected and active.
module spi_resp_slv #(
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          SS_n,
    input  logic          SCLK,
    input  logic          MOSI,
    output logic          MISO,
    input  logic          wrt,
    input  logic [DW-1:0] tx_data,
    output logic          rsp_rdy,
    output logic [DW-1:0] cmd_rcvd,
    output logic          cmd_rdy,
    input  logic          clr_cmd_rdy,
    output logic          frame_err
);

    localparam int CW = $clog2(DW + 2);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   ss_prev_q, sclk_prev_q;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   fall_ss, rise_ss, rise_sclk, fall_sclk;

    state_t          state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   buf_q, buf_d;
    logic [DW-1:0]   cmd_q, cmd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sample_q, sample_d;
    logic            pend_q, pend_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            rsp_rdy_q, rsp_rdy_d;
    logic            err_q, err_d;
    logic            miso_q, miso_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '1;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign fall_ss   = ss_prev_q & ~ss_s;
    assign rise_ss   = ~ss_prev_q & ss_s;
    assign rise_sclk = ~sclk_prev_q & sclk_s;
    assign fall_sclk = sclk_prev_q & ~sclk_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT_HIGH;
            shift_q   <= '0;
            buf_q     <= '0;
            cmd_q     <= '0;
            cnt_q     <= '0;
            sample_q  <= 1'b0;
            pend_q    <= 1'b0;
            cmd_rdy_q <= 1'b0;
            rsp_rdy_q <= 1'b0;
            err_q     <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            buf_q     <= buf_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            pend_q    <= pend_d;
            cmd_rdy_q <= cmd_rdy_d;
            rsp_rdy_q <= rsp_rdy_d;
            err_q     <= err_d;
            miso_q    <= miso_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        buf_d     = buf_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        pend_d    = pend_q;
        cmd_rdy_d = cmd_rdy_q;
        rsp_rdy_d = rsp_rdy_q;
        err_d     = 1'b0;
        miso_d    = (state_q == ACTIVE) ? shift_q[DW-1] : 1'b0;

        if (wrt) begin
            buf_d     = tx_data;
            rsp_rdy_d = 1'b1;
        end
        if (clr_cmd_rdy)
            cmd_rdy_d = 1'b0;

        case (state_q)
            // Synchronizer flops come out of reset high, so SS_n must be seen high
            // for the full chain depth before it is trusted; this drops a torn frame.
            WAIT_HIGH: begin
                if (!ss_s)
                    cnt_d = '0;
                else if (cnt_q == CW'(SYNC_STAGES)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else
                    cnt_d = cnt_q + CW'(1);
            end
            IDLE: begin
                if (fall_ss) begin
                    shift_d   = wrt ? tx_data : buf_q;
                    cnt_d     = '0;
                    pend_d    = 1'b0;
                    rsp_rdy_d = 1'b0;
                    cmd_rdy_d = 1'b0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (rise_sclk) begin
                    sample_d = mosi_s;
                    pend_d   = 1'b1;
                    if (cnt_q != CW'(DW + 1))
                        cnt_d = cnt_q + CW'(1);
                end
                if (fall_sclk) begin
                    shift_d = {shift_q[DW-2:0], sample_q};
                    pend_d  = 1'b0;
                end
                if (rise_ss) begin
                    state_d = IDLE;
                    if (cnt_q == CW'(DW)) begin
                        // Fold in the last sample if its SCLK fall never arrived.
                        cmd_d     = pend_q ? {shift_q[DW-2:0], sample_q} : shift_q;
                        cmd_rdy_d = 1'b1;
                    end else
                        err_d = 1'b1;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

`ifdef SPI_RESP_TRI_EN
    assign MISO = (ss_s || (state_q != ACTIVE)) ? 1'bz : miso_q;
`else
    assign MISO = miso_q;
`endif

    assign rsp_rdy   = rsp_rdy_q;
    assign cmd_rcvd  = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = err_q;

endmodule
